ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter. Sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard using the PS/2 request-to-send sequence: inhibit, start bit, 8 data bits LSB first, odd parity, stop, then the device ACK. It sits beside the PS/2 receive path and drives the open-drain clock and data lines through output-enable ports. The top level maps each `*_oe` to a pull-low tristate.

---
 rtl/ps2_tx_pkg.sv | 28 ++
 rtl/ps2_tx_clk_filter.sv | 48 ++++
 rtl/ps2_tx.sv | 169 ++++++++++++++++
 tb/tb_ps2_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_tx_pkg.sv
// Shared PS/2 definitions: transmit FSM encoding, command/response bytes and frame builder.
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StShift,
    StAck,
    StWaitIdle,
    StDone,
    StFail
  } tx_state_e;

  localparam logic [7:0] CmdSetLeds = 8'hED;
  localparam logic [7:0] CmdEnable  = 8'hF4;
  localparam logic [7:0] CmdReset   = 8'hFF;
  localparam logic [7:0] RspAck     = 8'hFA;
  localparam logic [7:0] BreakCode  = 8'hF0;

  localparam int unsigned FrameBits = 10;

  // Host-to-device frame after the start bit: data LSB first, odd parity, stop.
  function automatic logic [FrameBits-1:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_tx_clk_filter.sv
// PS/2 line conditioning: 2-FF synchronizers, clock glitch filter and falling-edge strobe.
module ps2_tx_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic clk_filt_o,
  output logic data_sync_o,
  output logic fall_o
);

  logic [1:0]            c_sync_q;
  logic [1:0]            d_sync_q;
  logic [FILTER_LEN-1:0] taps_q, taps_d;
  logic                  filt_q, filt_d;

  always_comb begin
    taps_d = {taps_q[FILTER_LEN-2:0], c_sync_q[1]};
    filt_d = filt_q;
    // Filtered clock only moves once every tap agrees.
    if (&taps_q) begin
      filt_d = 1'b1;
    end else if (~|taps_q) begin
      filt_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      taps_q   <= '1;
      filt_q   <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_i};
      d_sync_q <= {d_sync_q[0], ps2d_i};
      taps_q   <= taps_d;
      filt_q   <= filt_d;
    end
  end

  assign clk_filt_o  = filt_q;
  assign data_sync_o = d_sync_q[1];
  assign fall_o      = filt_q & ~|taps_q;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one byte, check ACK.
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk_rx,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [InhW-1:0] InhMax  = InhW'(INHIBIT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);

  logic clk_filt;
  logic data_sync;
  logic fall;

  ps2_tx_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk_i       (clk_rx),
    .rst_i       (reset),
    .ps2c_i      (ps2c_in),
    .ps2d_i      (ps2d_in),
    .clk_filt_o  (clk_filt),
    .data_sync_o (data_sync),
    .fall_o      (fall)
  );

  tx_state_e            state_q, state_d;
  logic [FrameBits-1:0] frame_q, frame_d;
  logic [3:0]           bit_q, bit_d;
  logic [InhW-1:0]      inh_cnt_q, inh_cnt_d;
  logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                 c_oe_q, c_oe_d;
  logic                 d_oe_q, d_oe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 timeout;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    inh_cnt_d = inh_cnt_q;
    d_oe_d    = d_oe_q;

    // Held at zero through INHIBIT so RTS entry starts from a clean count.
    if (state_q == StInhibit || fall) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TmoMax) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
    timeout = (tmo_cnt_q >= TmoLast);

    unique case (state_q)
      StIdle: begin
        d_oe_d = 1'b0;
        if (tx_start) begin
          frame_d   = build_frame(tx_data);
          inh_cnt_d = '0;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (inh_cnt_q != InhMax) begin
          inh_cnt_d = inh_cnt_q + InhW'(1);
        end
        if (inh_cnt_q == InhLast) begin
          d_oe_d = 1'b1;
        end
        if (d_oe_q) begin
          state_d = StRts;
        end
      end
      StRts: begin
        bit_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (fall) begin
          d_oe_d = ~frame_q[bit_q];
          bit_d  = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        if (fall) begin
          state_d = data_sync ? StFail : StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (clk_filt && data_sync) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (timeout && (state_q inside {StRts, StShift, StAck, StWaitIdle})) begin
      state_d = StFail;
    end
    if (state_d == StFail) begin
      d_oe_d = 1'b0;
    end

    // Outputs registered off the next state so the pads never see decode glitches.
    c_oe_d = (state_d == StInhibit);
    busy_d = !(state_d inside {StIdle, StDone, StFail});
    done_d = (state_d == StDone);
    err_d  = (state_d == StFail);
  end

  always_ff @(posedge clk_rx) begin
    if (reset) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      bit_q     <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      c_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      c_oe_q    <= c_oe_d;
      d_oe_q    <= d_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2c_oe = c_oe_q;
  assign ps2d_oe = d_oe_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign tx_err  = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx against a wired-AND keyboard model clocking at a 60 us period.
`timescale 1ns/1ps
module tb_ps2_tx;

  logic       clk_rx   = 1'b0;
  logic       reset    = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err;
  logic       bfm_clk  = 1'b1;
  logic       bfm_data = 1'b1;
  logic       ps2c_line, ps2d_line;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  logic [9:0] bits;
  bit         seen;
  int         n;

  assign ps2c_line = bfm_clk & ~ps2c_oe;
  assign ps2d_line = bfm_data & ~ps2d_oe;

  ps2_tx #(
    .INHIBIT_CYCLES (100),
    .TIMEOUT_CYCLES (2000),
    .FILTER_LEN     (8)
  ) dut (
    .clk_rx   (clk_rx),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .ps2c_in  (ps2c_line),
    .ps2d_in  (ps2d_line),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  always #50 clk_rx = ~clk_rx;

  always @(negedge clk_rx) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_rx);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && tx_busy; i++) step();
  endtask

  // Keyboard model: waits for request-to-send, then generates nclk clocks,
  // capturing the host bit at the end of each low phase.
  task automatic bfm(input int nclk, input bit ack, output logic [9:0] got, output bit rts);
    got = '0;
    rts = 1'b0;
    for (int i = 0; i < 4000 && !rts; i++) begin
      if (ps2d_oe && !ps2c_oe) rts = 1'b1;
      else step();
    end
    if (rts) begin
      #10_000;
      for (int i = 0; i < nclk; i++) begin
        bfm_clk = 1'b0;
        #30_000;
        if (i < 10) got[i] = ps2d_line;
        bfm_clk = 1'b1;
        #15_000;
        if (i == 9 && ack) bfm_data = 1'b0;
        if (i == 10) bfm_data = 1'b1;
        #15_000;
      end
    end
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_c_oe", ps2c_oe, 0);
    chk("rst_d_oe", ps2d_oe, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);

    // 0xED with ACK, plus inhibit/RTS timing
    send(8'hED);
    chk("accept_busy", tx_busy, 1);
    chk("accept_c_oe", ps2c_oe, 1);
    chk("accept_d_oe", ps2d_oe, 0);
    n = 0;
    while (!ps2d_oe && n < 1000) begin step(); n++; end
    chk("inhibit_len", n, 100);
    chk("start_c_oe_held", ps2c_oe, 1);
    step();
    chk("rts_c_oe", ps2c_oe, 0);
    chk("rts_d_oe", ps2d_oe, 1);
    bfm(11, 1'b1, bits, seen);
    chk("ed_rts", seen, 1);
    chk("ed_bits", bits, 10'h3ED);
    wait_idle();
    chk("ed_busy", tx_busy, 0);
    chk("ed_done_cnt", done_cnt, 1);
    chk("ed_err_cnt", err_cnt, 0);

    // Parity 0 then 1
    send(8'h01);
    bfm(11, 1'b1, bits, seen);
    chk("b01_bits", bits, 10'h201);
    wait_idle();
    chk("b01_done_cnt", done_cnt, 2);
    send(8'hFF);
    bfm(11, 1'b1, bits, seen);
    chk("bff_bits", bits, 10'h3FF);
    wait_idle();
    chk("bff_done_cnt", done_cnt, 3);

    // Missing ACK
    send(8'hF4);
    bfm(11, 1'b0, bits, seen);
    chk("nak_bits", bits, 10'h2F4);
    wait_idle();
    chk("nak_err_cnt", err_cnt, 1);
    chk("nak_done_cnt", done_cnt, 3);
    chk("nak_c_oe", ps2c_oe, 0);
    chk("nak_d_oe", ps2d_oe, 0);
    chk("nak_busy", tx_busy, 0);

    // Device never clocks
    send(8'hFF);
    n = 0;
    while (!(ps2d_oe && !ps2c_oe) && n < 1000) begin step(); n++; end
    chk("tmo_rts_n", n, 101);
    n = 0;
    while (!tx_err && n < 3000) begin step(); n++; end
    chk("tmo_len", n, 2000);
    chk("tmo_c_oe", ps2c_oe, 0);
    chk("tmo_d_oe", ps2d_oe, 0);
    chk("tmo_busy", tx_busy, 0);
    step();
    chk("tmo_err_cnt", err_cnt, 2);

    // Reset after the 5th fall, then a clean 0xF4
    send(8'hED);
    bfm(5, 1'b1, bits, seen);
    chk("rstmid_bits", bits[4:0], 5'b01101);
    chk("rstmid_d_oe_before", ps2d_oe, 1);
    reset = 1'b1;
    step();
    chk("rstmid_c_oe", ps2c_oe, 0);
    chk("rstmid_d_oe", ps2d_oe, 0);
    chk("rstmid_busy", tx_busy, 0);
    reset = 1'b0;
    repeat (20) step();
    chk("rstmid_done_cnt", done_cnt, 3);
    chk("rstmid_err_cnt", err_cnt, 2);
    send(8'hF4);
    bfm(11, 1'b1, bits, seen);
    chk("f4_bits", bits, 10'h2F4);
    wait_idle();
    chk("f4_done_cnt", done_cnt, 4);

    // tx_start while busy is dropped
    send(8'hED);
    repeat (3) step();
    tx_data  = 8'h55;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    bfm(11, 1'b1, bits, seen);
    chk("busy_req_bits", bits, 10'h3ED);
    wait_idle();
    chk("busy_req_done_cnt", done_cnt, 5);
    repeat (200) step();
    chk("busy_req_no_queue_c_oe", ps2c_oe, 0);
    chk("busy_req_no_queue_busy", tx_busy, 0);
    chk("final_err_cnt", err_cnt, 2);
    chk("done_err_overlap", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
